// File: rtl/pulse_gate_ctrl.sv
// pulse_gate_ctrl: measurement-window sequencer for an external pulse counter
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   start, abort      begin a window (from IDLE) / cancel from any busy state
//   cont_mode         re-arm automatically after each result handshake
//   gate_len          window length in clk cycles (0 treated as 1)
//   count             live counter value
//   en_count, cnt_clr counter enable and one-cycle clear
//   result, result_wrap, result_valid, result_ready  captured count, wrap flag, handshake
//   busy              high whenever not IDLE
module pulse_gate_ctrl #(
    parameter int CNT_W      = 16,
    parameter int GATE_W     = 24,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              cont_mode,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [CNT_W-1:0]  count,
    output logic              en_count,
    output logic              cnt_clr,
    output logic [CNT_W-1:0]  result,
    output logic              result_wrap,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, OUT} state_t;
    state_t state, state_nx;
    logic [GATE_W-1:0] cyc_cnt;
    logic [CNT_W-1:0]  prev;
    logic wrap, wrap_nx, last, en_nx, clr_nx, valid_nx, busy_nx;
    // cyc_cnt counts down the gate window, then is reloaded for the settle phase
    assign last    = cyc_cnt == GATE_W'(1);
    // a drop in count between consecutive samples can only come from a wrap
    assign wrap_nx = wrap | (count < prev);
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            en_count     <= 1'b0;
            cnt_clr      <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_wrap  <= 1'b0;
            cyc_cnt      <= '0;
            prev         <= '0;
            wrap         <= 1'b0;
        end else begin
            state        <= state_nx;
            en_count     <= en_nx;
            cnt_clr      <= clr_nx;
            result_valid <= valid_nx;
            busy         <= busy_nx;
            if (state_nx == CLEAR)
                cyc_cnt <= (gate_len == '0) ? GATE_W'(1) : gate_len;
            else if (state == GATE && state_nx == SETTLE)
                cyc_cnt <= GATE_W'(SETTLE_CYC);
            else if (state == GATE || state == SETTLE)
                cyc_cnt <= cyc_cnt - GATE_W'(1);
            if (state == CLEAR) begin
                prev <= '0;
                wrap <= 1'b0;
            end else if (state == GATE || state == SETTLE) begin
                prev <= count;
                wrap <= wrap_nx;
            end
            // include the current sample so a wrap on the final gate edge is not missed
            if (state == SETTLE && state_nx == OUT) begin
                result      <= count;
                result_wrap <= wrap_nx;
            end
        end
    end
    always_comb begin
        state_nx = state;
        if (state != IDLE && abort)
            state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = (start && !abort) ? CLEAR : IDLE;
                CLEAR:   state_nx = GATE;
                GATE:    state_nx = last ? SETTLE : GATE;
                SETTLE:  state_nx = last ? OUT : SETTLE;
                OUT:     state_nx = !result_ready ? OUT : (cont_mode ? CLEAR : IDLE);
                default: state_nx = IDLE;
            endcase
    end
    // outputs are registered from the next state so they line up with the state register
    always_comb begin
        en_nx    = state_nx == GATE;
        clr_nx   = state_nx == CLEAR;
        valid_nx = state_nx == OUT;
        busy_nx  = state_nx != IDLE;
    end
endmodule
